// File: rtl/multichannel_envelope_if.sv
// Config, note-state and output bus of the multichannel envelope generator.
// The generator connects through the slave modport; the driver uses master.
interface multichannel_envelope_if #(
    parameter int NUM_CHANNELS = 256,
    parameter int LEVEL_WIDTH  = 8
);
    localparam int CW = $clog2(NUM_CHANNELS);

    logic                   i_ConfigWriteEnable;
    logic [CW-1:0]          i_ConfigChannel;
    logic [2:0]             i_ConfigParam;
    logic [LEVEL_WIDTH-1:0] i_ConfigValue;
    logic                   i_NoteWriteEnable;
    logic [CW-1:0]          i_NoteChannel;
    logic                   i_NoteOn;
    logic                   o_Valid;
    logic [CW-1:0]          o_Channel;
    logic [LEVEL_WIDTH-1:0] o_Level;
    logic                   o_FrameStart;

    modport master (
        output i_ConfigWriteEnable, i_ConfigChannel, i_ConfigParam, i_ConfigValue,
        output i_NoteWriteEnable, i_NoteChannel, i_NoteOn,
        input  o_Valid, o_Channel, o_Level, o_FrameStart
    );

    modport slave (
        input  i_ConfigWriteEnable, i_ConfigChannel, i_ConfigParam, i_ConfigValue,
        input  i_NoteWriteEnable, i_NoteChannel, i_NoteOn,
        output o_Valid, o_Channel, o_Level, o_FrameStart
    );
endinterface

// File: rtl/multichannel_envelope.sv
// Time-multiplexed four-rate/four-level envelope generator, one channel per clock.
// Optional MULTICHANNEL_ENVELOPE_RETRIGGER_EN: rising note-on outside MUTE re-enters ATTACK.
module multichannel_envelope #(
    parameter int NUM_CHANNELS = 256,
    parameter int LEVEL_WIDTH  = 8,
    parameter int RATE_WIDTH   = 8,
    parameter int TICK_FRAMES  = 1024
) (
    input logic                   i_Clock,
    input logic                   i_Reset,
    multichannel_envelope_if.slave bus
);
    localparam int CW = $clog2(NUM_CHANNELS);
    localparam int FW = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
    localparam logic [FW-1:0] TICK_LAST = FW'(TICK_FRAMES - 1);
    localparam logic [CW-1:0] LAST_CH   = CW'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {
        MUTE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY1  = 3'd2,
        DECAY2  = 3'd3,
        SUSTAIN = 3'd4,
        RELEASE = 3'd5
    } env_state_e;

    // Per-channel state is packed so reset can clear it in one assignment.
    logic [NUM_CHANNELS-1:0][2:0]             state_mem;
    logic [NUM_CHANNELS-1:0][LEVEL_WIDTH-1:0] level_mem;
    logic [NUM_CHANNELS-1:0]                  note_mem;
`ifdef MULTICHANNEL_ENVELOPE_RETRIGGER_EN
    logic [NUM_CHANNELS-1:0]                  prev_mem;
    logic                                     note_rise;
`endif
    logic [LEVEL_WIDTH-1:0] target_cfg [NUM_CHANNELS][4];
    logic [RATE_WIDTH-1:0]  rate_cfg   [NUM_CHANNELS][4];

    logic [CW-1:0]          scan_ch;
    logic [FW-1:0]          frame_cnt;
    logic                   tick;
    env_state_e             cur_state, next_state;
    logic [LEVEL_WIDTH-1:0] cur_level, next_level, stage_target;
    logic [RATE_WIDTH-1:0]  stage_rate;
    logic [1:0]             stage_idx;
    logic                   cur_note, at_target;

    // Move level toward target by rate, clamping at the target; widened so it never wraps.
    function automatic logic [LEVEL_WIDTH-1:0] step_level(
        input logic [LEVEL_WIDTH-1:0] level,
        input logic [LEVEL_WIDTH-1:0] target,
        input logic [RATE_WIDTH-1:0]  rate
    );
        logic [LEVEL_WIDTH:0] lvl_x, tgt_x, rate_x, sum_x, floor_x;
        lvl_x   = {1'b0, level};
        tgt_x   = {1'b0, target};
        rate_x  = {{(LEVEL_WIDTH + 1 - RATE_WIDTH){1'b0}}, rate};
        sum_x   = lvl_x + rate_x;
        floor_x = tgt_x + rate_x;
        step_level = level;
        if (lvl_x < tgt_x)
            step_level = (sum_x > tgt_x) ? target : sum_x[LEVEL_WIDTH-1:0];
        else if (lvl_x > tgt_x)
            step_level = (lvl_x < floor_x) ? target : level - rate_x[LEVEL_WIDTH-1:0];
    endfunction

    always_ff @(posedge i_Clock) begin
        if (bus.i_ConfigWriteEnable) begin
            if (bus.i_ConfigParam[2])
                rate_cfg[bus.i_ConfigChannel][bus.i_ConfigParam[1:0]] <= bus.i_ConfigValue[RATE_WIDTH-1:0];
            else
                target_cfg[bus.i_ConfigChannel][bus.i_ConfigParam[1:0]] <= bus.i_ConfigValue;
        end
    end

    always_comb begin
        cur_state = env_state_e'(state_mem[scan_ch]);
        cur_level = level_mem[scan_ch];
        cur_note  = note_mem[scan_ch];
        tick      = (frame_cnt == TICK_LAST);
        stage_idx = 2'd0;
        case (cur_state)
            DECAY1:          stage_idx = 2'd1;
            DECAY2, SUSTAIN: stage_idx = 2'd2;
            RELEASE:         stage_idx = 2'd3;
            default:         stage_idx = 2'd0;
        endcase
        stage_target = target_cfg[scan_ch][stage_idx];
        stage_rate   = rate_cfg[scan_ch][stage_idx];
    end

`ifdef MULTICHANNEL_ENVELOPE_RETRIGGER_EN
    assign note_rise = cur_note & ~prev_mem[scan_ch];
`endif

    always_comb begin
        next_level = cur_level;
        case (cur_state)
            MUTE:    next_level = '0;
            SUSTAIN: next_level = stage_target;
            ATTACK, DECAY1, DECAY2, RELEASE:
                if (tick) next_level = step_level(cur_level, stage_target, stage_rate);
            default: next_level = '0;
        endcase
        at_target = (next_level == stage_target);
    end

    // Transitions take effect on the channel's next slot; this slot's step uses the old state.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            MUTE:    if (cur_note) next_state = ATTACK;
            ATTACK:  if (!cur_note) next_state = RELEASE; else if (at_target) next_state = DECAY1;
            DECAY1:  if (!cur_note) next_state = RELEASE; else if (at_target) next_state = DECAY2;
            DECAY2:  if (!cur_note) next_state = RELEASE; else if (at_target) next_state = SUSTAIN;
            SUSTAIN: if (!cur_note) next_state = RELEASE;
            RELEASE: if (at_target) next_state = MUTE;
            default: next_state = MUTE;
        endcase
`ifdef MULTICHANNEL_ENVELOPE_RETRIGGER_EN
        if (cur_state != MUTE && note_rise) next_state = ATTACK;
`endif
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            scan_ch          <= '0;
            frame_cnt        <= '0;
            state_mem        <= '0;
            level_mem        <= '0;
            note_mem         <= '0;
`ifdef MULTICHANNEL_ENVELOPE_RETRIGGER_EN
            prev_mem         <= '0;
`endif
            bus.o_Valid      <= 1'b0;
            bus.o_Channel    <= '0;
            bus.o_Level      <= '0;
            bus.o_FrameStart <= 1'b0;
        end else begin
            scan_ch <= scan_ch + 1'b1;
            if (scan_ch == LAST_CH)
                frame_cnt <= tick ? '0 : frame_cnt + 1'b1;
            state_mem[scan_ch] <= next_state;
            level_mem[scan_ch] <= next_level;
`ifdef MULTICHANNEL_ENVELOPE_RETRIGGER_EN
            prev_mem[scan_ch]  <= cur_note;
`endif
            if (bus.i_NoteWriteEnable)
                note_mem[bus.i_NoteChannel] <= bus.i_NoteOn;
            bus.o_Valid      <= 1'b1;
            bus.o_Channel    <= scan_ch;
            bus.o_Level      <= next_level;
            bus.o_FrameStart <= (scan_ch == '0);
        end
    end
endmodule

// File: tb/tb_multichannel_envelope.sv
// Directed bench: four-channel generator with tick every frame, plus a second
// instance with a three-frame tick.
module tb_multichannel_envelope;
    localparam int NCH = 4;
    localparam int LW  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_b = 1'b1;
    int tests_run = 0;
    int tests_failed = 0;
    int exp_q[$];
    logic [7:0] lvl;

    always #5 clk = ~clk;

    multichannel_envelope_if #(.NUM_CHANNELS(NCH), .LEVEL_WIDTH(LW)) bus_a ();
    multichannel_envelope_if #(.NUM_CHANNELS(NCH), .LEVEL_WIDTH(LW)) bus_b ();

    multichannel_envelope #(.NUM_CHANNELS(NCH), .LEVEL_WIDTH(LW), .RATE_WIDTH(8), .TICK_FRAMES(1))
        dut_a (.i_Clock(clk), .i_Reset(rst), .bus(bus_a));
    multichannel_envelope #(.NUM_CHANNELS(NCH), .LEVEL_WIDTH(LW), .RATE_WIDTH(8), .TICK_FRAMES(3))
        dut_b (.i_Clock(clk), .i_Reset(rst_b), .bus(bus_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cfg(input bit b, input int ch, input int prm, input int val);
        if (b) begin
            bus_b.i_ConfigWriteEnable = 1'b1; bus_b.i_ConfigChannel = ch[1:0];
            bus_b.i_ConfigParam = prm[2:0];   bus_b.i_ConfigValue = val[7:0];
        end else begin
            bus_a.i_ConfigWriteEnable = 1'b1; bus_a.i_ConfigChannel = ch[1:0];
            bus_a.i_ConfigParam = prm[2:0];   bus_a.i_ConfigValue = val[7:0];
        end
        @(negedge clk);
        bus_a.i_ConfigWriteEnable = 1'b0;
        bus_b.i_ConfigWriteEnable = 1'b0;
    endtask

    task automatic set_env(input bit b, input int ch, input int l1, input int l2, input int l3,
                           input int l4, input int r1, input int r2, input int r3, input int r4);
        cfg(b, ch, 0, l1); cfg(b, ch, 1, l2); cfg(b, ch, 2, l3); cfg(b, ch, 3, l4);
        cfg(b, ch, 4, r1); cfg(b, ch, 5, r2); cfg(b, ch, 6, r3); cfg(b, ch, 7, r4);
    endtask

    task automatic note(input bit b, input int ch, input bit on);
        if (b) begin
            bus_b.i_NoteWriteEnable = 1'b1; bus_b.i_NoteChannel = ch[1:0]; bus_b.i_NoteOn = on;
        end else begin
            bus_a.i_NoteWriteEnable = 1'b1; bus_a.i_NoteChannel = ch[1:0]; bus_a.i_NoteOn = on;
        end
        @(negedge clk);
        bus_a.i_NoteWriteEnable = 1'b0;
        bus_b.i_NoteWriteEnable = 1'b0;
    endtask

    // Advance to the next output word of channel ch; a missed word counts as a failure.
    task automatic wait_out(input bit b, input int ch, output logic [7:0] level);
        bit found = 1'b0;
        level = 'x;
        for (int n = 0; n < 12 && !found; n++) begin
            @(negedge clk);
            if (b) begin
                if (bus_b.o_Valid && bus_b.o_Channel == ch[1:0]) begin found = 1'b1; level = bus_b.o_Level; end
            end else begin
                if (bus_a.o_Valid && bus_a.o_Channel == ch[1:0]) begin found = 1'b1; level = bus_a.o_Level; end
            end
        end
        if (!found) check($sformatf("wait_ch%0d", ch), 32'(found), 32'd1);
    endtask

    task automatic run_seq(input bit b, input int ch, input string tag);
        logic [7:0] l;
        for (int i = 0; i < exp_q.size(); i++) begin
            wait_out(b, ch, l);
            check($sformatf("%s[%0d]", tag, i), 32'(l), 32'(exp_q[i]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.i_ConfigWriteEnable = 1'b0; bus_a.i_ConfigChannel = '0; bus_a.i_ConfigParam = '0;
        bus_a.i_ConfigValue = '0; bus_a.i_NoteWriteEnable = 1'b0; bus_a.i_NoteChannel = '0;
        bus_a.i_NoteOn = 1'b0;
        bus_b.i_ConfigWriteEnable = 1'b0; bus_b.i_ConfigChannel = '0; bus_b.i_ConfigParam = '0;
        bus_b.i_ConfigValue = '0; bus_b.i_NoteWriteEnable = 1'b0; bus_b.i_NoteChannel = '0;
        bus_b.i_NoteOn = 1'b0;
        @(negedge clk);

        // Config registers are unaffected by reset, so load them while it is held.
        set_env(0, 0, 100, 100, 100, 0, 30, 1, 1, 25);
        set_env(0, 1, 100, 60, 80, 0, 30, 20, 5, 10);
        set_env(0, 2, 100, 100, 100, 0, 30, 1, 1, 25);
        set_env(0, 3, 255, 255, 255, 0, 200, 1, 1, 200);
        set_env(1, 1, 40, 0, 0, 0, 10, 0, 0, 0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_valid", 32'(bus_a.o_Valid), 32'd0);
            check("rst_level", 32'(bus_a.o_Level), 32'd0);
            check("rst_chan",  32'(bus_a.o_Channel), 32'd0);
            check("rst_fs",    32'(bus_a.o_FrameStart), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("scan_valid", 32'(bus_a.o_Valid), 32'd1);
            check("scan_chan",  32'(bus_a.o_Channel), 32'(i % 4));
            check("scan_fs",    32'(bus_a.o_FrameStart), 32'((i % 4) == 0));
        end

        // Full envelope; DECAY2 rises from 60 to 80.
        wait_out(0, 1, lvl); check("env_idle", 32'(lvl), 32'd0);
        note(0, 1, 1'b1);
        exp_q = '{0, 30, 60, 90, 100, 80, 60, 65, 70, 75, 80, 80};
        run_seq(0, 1, "env");

        // Release mid-attack; note-off slot still steps as ATTACK.
        wait_out(0, 2, lvl); check("rel_idle", 32'(lvl), 32'd0);
        note(0, 2, 1'b1);
        exp_q = '{0, 30};
        run_seq(0, 2, "rel_att");
        note(0, 2, 1'b0);
        exp_q = '{60, 35, 10, 0, 0};
        run_seq(0, 2, "rel");
        wait_out(0, 1, lvl); check("rel_other_ch", 32'(lvl), 32'd80);

        // Saturation both ways; later stages already at target exit at once.
        wait_out(0, 3, lvl); check("sat_idle", 32'(lvl), 32'd0);
        note(0, 3, 1'b1);
        exp_q = '{0, 200, 255, 255, 255, 255};
        run_seq(0, 3, "sat_up");
        note(0, 3, 1'b0);
        exp_q = '{255, 55, 0, 0};
        run_seq(0, 3, "sat_dn");

        // Note-on again while releasing.
        wait_out(0, 0, lvl); check("rtg_idle", 32'(lvl), 32'd0);
        note(0, 0, 1'b1);
        exp_q = '{0, 30};
        run_seq(0, 0, "rtg_att");
        note(0, 0, 1'b0);
        wait_out(0, 0, lvl); check("rtg_noteoff", 32'(lvl), 32'd60);
        note(0, 0, 1'b1);
`ifdef MULTICHANNEL_ENVELOPE_RETRIGGER_EN
        exp_q = '{35, 65, 95, 100};
`else
        exp_q = '{35, 10, 0, 0, 30};
`endif
        run_seq(0, 0, "rtg");

        // Rate 0 in DECAY1 holds the level indefinitely.
        cfg(0, 2, 0, 50); cfg(0, 2, 4, 25); cfg(0, 2, 1, 20); cfg(0, 2, 5, 0);
        wait_out(0, 2, lvl); check("r0_idle", 32'(lvl), 32'd0);
        note(0, 2, 1'b1);
        exp_q = '{0, 25, 50, 50, 50, 50, 50};
        run_seq(0, 2, "rate0");

        // Three-frame tick: frame 0 idle, note-on seen in frame 1, ticks on frames 2, 5, 8.
        rst_b = 1'b0;
        wait_out(1, 1, lvl); check("tick_idle", 32'(lvl), 32'd0);
        note(1, 1, 1'b1);
        exp_q = '{0, 10, 10, 10, 20, 20, 20, 30};
        run_seq(1, 1, "tick");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
